// File: rtl/chip8_timing_pkg.sv
// chip8_timing_pkg: shared timing constants, the accumulator width helper and
// the single-step FSM state type for the CHIP-8 rate-strobe generator.
// Contents: CLK_HZ_DEFAULT, TICK_HZ_DEFAULT, CPU_HZ_DEFAULT, acc_width(), step_state_t.
package chip8_timing_pkg;

    localparam int unsigned CLK_HZ_DEFAULT  = 50_000_000;
    localparam int unsigned TICK_HZ_DEFAULT = 60;
    localparam int unsigned CPU_HZ_DEFAULT  = 600;

    // Wide enough to hold acc + rate (always < clk_hz + rate_hz) with a spare bit.
    function automatic int acc_width(input int unsigned clk_hz, input int unsigned rate_hz);
        return $clog2(clk_hz + rate_hz) + 1;
    endfunction

    typedef enum logic {
        STEP_ARMED = 1'b0,
        STEP_FIRED = 1'b1
    } step_state_t;

endpackage

// File: rtl/chip8_tick_gen_rate_accum.sv
// rate_accum: one-cycle strobe at RATE_HZ derived from a CLK_HZ clock.
// Ports: clk, reset (async, active-high), en (count enable), strobe (registered pulse).
// Build option TICK_FRAC_CORR_EN: fractional accumulator (exact rate); otherwise
// a truncated-period down-counter. With en=0 the phase is held and strobe is 0.
module rate_accum
    import chip8_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned RATE_HZ = TICK_HZ_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic strobe
);

    if (RATE_HZ == 0 || RATE_HZ >= CLK_HZ) begin : g_bad_rate
        $error("rate_accum: RATE_HZ must satisfy 0 < RATE_HZ < CLK_HZ");
    end

    logic strobe_q;

`ifdef TICK_FRAC_CORR_EN
    localparam int W = acc_width(CLK_HZ, RATE_HZ);
    localparam logic [W-1:0] CLK_W  = W'(CLK_HZ);
    localparam logic [W-1:0] RATE_W = W'(RATE_HZ);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] acc_sum;
    logic         strobe_d;

    // acc stays below CLK_HZ, so the sum never overflows W bits.
    always_comb begin
        acc_sum  = acc_q + RATE_W;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        if (en) begin
            if (acc_sum >= CLK_W) begin
                acc_d    = acc_sum - CLK_W;
                strobe_d = 1'b1;
            end else begin
                acc_d    = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end
`else
    localparam int unsigned P  = CLK_HZ / RATE_HZ;
    localparam int          CW = (P > 1) ? $clog2(P) : 1;
    localparam logic [CW-1:0] P_M1 = CW'(P - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          strobe_d;

    // Counter starts at P-1 so the first strobe follows the P-th enabled edge.
    always_comb begin
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (en) begin
            if (cnt_q == '0) begin
                cnt_d    = P_M1;
                strobe_d = 1'b1;
            end else begin
                cnt_d    = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= P_M1;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
        end
    end
`endif

    assign strobe = strobe_q;

endmodule

// File: rtl/chip8_tick_gen.sv
// chip8_tick_gen: derives the 60 Hz timer strobe (tick_60) and the instruction
// pacing strobe (cpu_tick), with run/pause and a single-step handshake.
// Ports: clk, reset (async, active-high), run, step_req -> step_ack, tick_60,
// cpu_tick, frame_cnt[7:0]. Build option TICK_FRAC_CORR_EN selects exact
// fractional rates; undefined gives truncated integer periods.
module chip8_tick_gen
    import chip8_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned TICK_HZ = TICK_HZ_DEFAULT,
    parameter int unsigned CPU_HZ  = CPU_HZ_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step_req,
    output logic       step_ack,
    output logic       tick_60,
    output logic       cpu_tick,
    output logic [7:0] frame_cnt
);

    logic        rate_tick;
    logic        rate_cpu;
    step_state_t step_state_q;
    logic        step_ack_q;
    logic        step_take;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  frame_cnt_d;

    // The accumulators only advance while running; pausing freezes their phase.
    rate_accum #(
        .CLK_HZ  (CLK_HZ),
        .RATE_HZ (TICK_HZ)
    ) u_tick_accum (
        .clk    (clk),
        .reset  (reset),
        .en     (run),
        .strobe (rate_tick)
    );

    rate_accum #(
        .CLK_HZ  (CLK_HZ),
        .RATE_HZ (CPU_HZ)
    ) u_cpu_accum (
        .clk    (clk),
        .reset  (reset),
        .en     (run),
        .strobe (rate_cpu)
    );

    // run=1 has priority: a request seen while running is never taken.
    assign step_take = !run && step_req && (step_state_q == STEP_ARMED);

    // Re-arming only needs step_req low, independent of run, so a request held
    // across a run->pause transition is still honoured exactly once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_state_q <= STEP_ARMED;
            step_ack_q   <= 1'b0;
        end else begin
            step_ack_q <= step_take;
            case (step_state_q)
                STEP_ARMED: if (step_take) step_state_q <= STEP_FIRED;
                STEP_FIRED: if (!step_req) step_state_q <= STEP_ARMED;
                default:    step_state_q <= STEP_ARMED;
            endcase
        end
    end

    // While paused the rate strobes are 0, so the OR never merges two sources.
    assign tick_60  = rate_tick | step_ack_q;
    assign cpu_tick = rate_cpu  | step_ack_q;
    assign step_ack = step_ack_q;

    assign frame_cnt_d = frame_cnt_q + {7'd0, tick_60};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_chip8_tick_gen.sv
// Bench for chip8_tick_gen with CLK_HZ=10, TICK_HZ=3, CPU_HZ=4. A reference model
// counts enabled edges and decides strobes from floor(n*R/C) (fractional build)
// or n mod floor(C/R) (integer build); every cycle is compared against it.
module tb_chip8_tick_gen;

    localparam int unsigned C = 10;
    localparam int unsigned T = 3;
    localparam int unsigned U = 4;
`ifdef TICK_FRAC_CORR_EN
    localparam int K_EXP = (C + T - 1) / T;
`else
    localparam int K_EXP = C / T;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step_req;
    logic       step_ack;
    logic       tick_60;
    logic       cpu_tick;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    longint     n_en;
    bit         armed;
    bit         m_tick;
    bit         m_cpu;
    bit         m_ack;
    logic [7:0] m_frame;

    // Observation counters for directed sections
    int tick_seen;
    int ack_seen;

    chip8_tick_gen #(
        .CLK_HZ  (C),
        .TICK_HZ (T),
        .CPU_HZ  (U)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step_req  (step_req),
        .step_ack  (step_ack),
        .tick_60   (tick_60),
        .cpu_tick  (cpu_tick),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit fires(input longint n, input longint r);
`ifdef TICK_FRAC_CORR_EN
        return ((n * r) / C) != (((n - 1) * r) / C);
`else
        return (n % (C / r)) == 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n_en    = 0;
        armed   = 1'b1;
        m_tick  = 1'b0;
        m_cpu   = 1'b0;
        m_ack   = 1'b0;
        m_frame = 8'd0;
    endtask

    // Drive inputs, take one edge, update the model, compare #1 after the edge.
    task automatic cycle(input bit r, input bit q);
        bit take;
        run      = r;
        step_req = q;
        @(posedge clk);
        take    = !r && q && armed;
        m_frame = m_frame + (m_tick ? 8'd1 : 8'd0);
        if (r) begin
            n_en++;
            m_tick = fires(n_en, T);
            m_cpu  = fires(n_en, U);
        end else begin
            m_tick = take;
            m_cpu  = take;
        end
        m_ack = take;
        if (!q) armed = 1'b1;
        else if (take) armed = 1'b0;
        #1;
        check("tick_60", tick_60, m_tick);
        check("cpu_tick", cpu_tick, m_cpu);
        check("step_ack", step_ack, m_ack);
        check("frame_cnt", frame_cnt, m_frame);
        if (tick_60 === 1'b1) tick_seen++;
        if (step_ack === 1'b1) ack_seen++;
    endtask

    // Called 1 time unit after a posedge: reset lands between edges.
    task automatic async_reset_and_first_tick();
        int k;
        #2 reset = 1'b1;
        #1;
        check("rst_tick_60", tick_60, 1'b0);
        check("rst_cpu_tick", cpu_tick, 1'b0);
        check("rst_step_ack", step_ack, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'd0);
        model_reset();
        #2 reset = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0);
            if (tick_60 === 1'b1) begin
                k = i;
                break;
            end
        end
        check("first_tick_edges", k, K_EXP);
    endtask

    initial begin
        int k;
        reset    = 1'b1;
        run      = 1'b0;
        step_req = 1'b0;
        model_reset();
        #12;
        check("init_tick_60", tick_60, 1'b0);
        check("init_cpu_tick", cpu_tick, 1'b0);
        check("init_step_ack", step_ack, 1'b0);
        check("init_frame_cnt", frame_cnt, 8'd0);
        reset = 1'b0;

        // Free run from reset; step_req toggling must be ignored.
        tick_seen = 0;
        ack_seen  = 0;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)));
        check("run_ignores_step", ack_seen, 0);

        // Pause 2 cycles after a tick, hold 20 cycles, resume.
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            if (tick_60 === 1'b1) begin
                k = 1;
                break;
            end
        end
        check("pause_found_tick", k, 1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        tick_seen = 0;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);
        check("paused_no_ticks", tick_seen, 0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

        // Step handshake: long hold gives one step, then re-arm and step again.
        tick_seen = 0;
        ack_seen  = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
        check("step_hold_acks", ack_seen, 1);
        check("step_hold_ticks", tick_seen, 1);
        cycle(1'b0, 1'b0);
        ack_seen = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        check("step_rearm_acks", ack_seen, 1);
        cycle(1'b0, 1'b0);
        ack_seen = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
        check("step_while_run", ack_seen, 0);

        // Random mix of run/pause/step.
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

        // Wrap: from a fresh reset, drive more than 256 ticks.
        async_reset_and_first_tick();
        tick_seen = 1;
        for (int i = 0; i < 900; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("wrap_reached", (tick_seen >= 256), 1'b1);
        check("wrap_frame_cnt", frame_cnt, 8'(tick_seen));

        // Reset mid-period again, then confirm the period restarts from zero.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0);
        async_reset_and_first_tick();
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
